// File: rtl/div_iter_unit.sv
// Iterative 32-bit integer divider for DIV.W / DIV.WU / MOD.W / MOD.WU.
// Restoring radix-2: one quotient bit per clock, 32 steps, then a
// one-cycle valid pulse carrying the sign-fixed quotient or remainder.

package div_iter_pkg;
  // Execute-stage op encodings shared with decode.
  localparam logic [7:0] EXE_ADD_OP  = 8'h01;
  localparam logic [7:0] EXE_DIV_OP  = 8'h20;
  localparam logic [7:0] EXE_DIVU_OP = 8'h21;
  localparam logic [7:0] EXE_MOD_OP  = 8'h22;
  localparam logic [7:0] EXE_MODU_OP = 8'h23;
endpackage

module div_iter_unit
  import div_iter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 8,
  parameter int GPR_NUM      = 32,
  localparam int TAG_W       = $clog2(GPR_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ALU_OP_WIDTH-1:0] aluop_i,
  input  logic [DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]   divisor_i,
  input  logic [TAG_W-1:0]        wb_addr_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic [TAG_W-1:0]        wb_addr_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  localparam logic [5:0] LAST_STEP = 6'd31;

  state_e                state_q,  state_d;
  logic [DATA_WIDTH-1:0] rem_q,    rem_d;
  logic [DATA_WIDTH-1:0] quo_q,    quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q,   dvsr_d;
  logic [5:0]            cnt_q,    cnt_d;
  logic                  is_mod_q, is_mod_d;
  logic                  q_neg_q,  q_neg_d;
  logic                  r_neg_q,  r_neg_d;
  logic [TAG_W-1:0]      tag_q,    tag_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0]      wb_addr_q, wb_addr_d;

  // Request decode on the raw inputs.
  logic                  op_div, op_divu, op_mod, op_modu;
  logic                  op_valid, op_signed, op_is_mod;
  logic                  a_neg, b_neg, div_zero, accept;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;

  // One restoring step: shifted partial remainder and its trial subtraction.
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] trial;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] step_rem, step_quo, raw_res;
  logic                  fix_neg;

  // Decode the op, take operand magnitudes and evaluate the current step.
  always_comb begin
    op_div    = (aluop_i == EXE_DIV_OP);
    op_divu   = (aluop_i == EXE_DIVU_OP);
    op_mod    = (aluop_i == EXE_MOD_OP);
    op_modu   = (aluop_i == EXE_MODU_OP);
    op_valid  = op_div | op_divu | op_mod | op_modu;
    op_signed = op_div | op_mod;
    op_is_mod = op_mod | op_modu;
    a_neg     = op_signed & dividend_i[DATA_WIDTH-1];
    b_neg     = op_signed & divisor_i[DATA_WIDTH-1];
    a_mag     = a_neg ? ('0 - dividend_i) : dividend_i;
    b_mag     = b_neg ? ('0 - divisor_i)  : divisor_i;
    div_zero  = (divisor_i == '0);
    accept    = (state_q == ST_IDLE) & start_i & op_valid & ~flush_i;

    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = {1'b0, shifted} - {2'b00, dvsr_q};
    borrow    = trial[DATA_WIDTH+1];
    step_rem  = borrow ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    step_quo  = {quo_q[DATA_WIDTH-2:0], ~borrow};
    raw_res   = is_mod_q ? step_rem : step_quo;
    fix_neg   = is_mod_q ? r_neg_q : q_neg_q;
  end

  // Next-state logic; flush overrides everything and returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = div_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == LAST_STEP) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Datapath updates: load on accept, iterate in CALC, register the result on entry to DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    is_mod_d  = is_mod_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    tag_d     = tag_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;

    if (accept) begin
      if (div_zero) begin
        result_d  = op_is_mod ? dividend_i : '1;
        wb_addr_d = wb_addr_i;
      end else begin
        rem_d    = '0;
        quo_d    = a_mag;
        dvsr_d   = b_mag;
        cnt_d    = '0;
        is_mod_d = op_is_mod;
        q_neg_d  = a_neg ^ b_neg;
        r_neg_d  = a_neg;
        tag_d    = wb_addr_i;
      end
    end else if (state_q == ST_CALC && !flush_i) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LAST_STEP) begin
        result_d  = fix_neg ? ('0 - raw_res) : raw_res;
        wb_addr_d = tag_q;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      is_mod_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      is_mod_q  <= is_mod_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    ready_o   = (state_q == ST_IDLE);
    valid_o   = (state_q == ST_DONE);
    result_o  = result_q;
    wb_addr_o = wb_addr_q;
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: table of divide/modulo vectors
// issued back-to-back through a scoreboard, plus flush/reset/ignore sequences.

module tb_div_iter_unit;
  import div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  aluop_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  wb_addr_i;
  logic        flush_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  wb_addr_o;

  always #5 clk = ~clk;

  div_iter_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .aluop_i    (aluop_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .wb_addr_i  (wb_addr_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .wb_addr_o  (wb_addr_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;  // cycle index just after the accepting edge
    int          lat;  // edges from acceptance to the valid cycle
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; sample at the falling edge and score any valid pulse.
  task automatic step();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL stray_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        check("wb_addr", 32'(wb_addr_o), 32'(e.rd));
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp);
    int n = 0;
    sb_t e;
    while (ready_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
    start_i    = 1'b1;
    aluop_i    = op;
    dividend_i = a;
    divisor_i  = b;
    wb_addr_i  = rd;
    if (push) begin
      e.res = exp;
      e.rd  = rd;
      e.acc = cyc + 1;
      e.lat = (b == 32'd0) ? 0 : 32;
      sb_q.push_back(e);
    end
    step();
    start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending results", sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{EXE_DIV_OP,  32'd100,        32'd7,          5'd5,  32'd14};
    vecs[1]  = '{EXE_MOD_OP,  32'd100,        32'd7,          5'd6,  32'd2};
    vecs[2]  = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD};
    vecs[3]  = '{EXE_MOD_OP,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF};
    vecs[4]  = '{EXE_MOD_OP,  32'd7,          32'hFFFF_FFFE,  5'd3,  32'd1};
    vecs[5]  = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'd2,          5'd4,  32'h7FFF_FFFF};
    vecs[6]  = '{EXE_MODU_OP, 32'hFFFF_FFFF,  32'd2,          5'd7,  32'd1};
    vecs[7]  = '{EXE_DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000};
    vecs[8]  = '{EXE_MOD_OP,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0};
    vecs[9]  = '{EXE_DIV_OP,  32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF};
    vecs[10] = '{EXE_MOD_OP,  32'd5,          32'd0,          5'd11, 32'd5};
    vecs[11] = '{EXE_DIVU_OP, 32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF};
    vecs[12] = '{EXE_MODU_OP, 32'h1234_5678,  32'd0,          5'd13, 32'h1234_5678};
    vecs[13] = '{EXE_DIV_OP,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd14, 32'd14};
    vecs[14] = '{EXE_MOD_OP,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd15, 32'hFFFF_FFFE};
    vecs[15] = '{EXE_MODU_OP, 32'hDEAD_BEEF,  32'h0001_0000,  5'd31, 32'h0000_BEEF};
    vecs[16] = '{EXE_DIVU_OP, 32'd3,          32'd5,          5'd16, 32'd0};

    rst        = 1'b1;
    start_i    = 1'b0;
    aluop_i    = '0;
    dividend_i = '0;
    divisor_i  = '0;
    wb_addr_i  = '0;
    flush_i    = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_wb_addr", 32'(wb_addr_o), 32'd0);
    rst = 1'b0;
    step();

    // Table vectors issued back-to-back.
    for (int i = 0; i < 17; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, vecs[i].exp);
    drain();

    // Flush in the middle of CALC: no pulse, outputs hold, unit idles next cycle.
    issue(EXE_DIV_OP, 32'd1000, 32'd3, 5'd9, 1'b0, 32'd0);
    repeat (9) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_result_hold", result_o, vecs[16].exp);
    check("flush_wb_hold", 32'(wb_addr_o), 32'(vecs[16].rd));
    repeat (40) step();
    issue(EXE_DIV_OP, 32'd1000, 32'd3, 5'd9, 1'b1, 32'd333);
    drain();

    // Flush and start in the same cycle: request dropped.
    start_i    = 1'b1;
    flush_i    = 1'b1;
    aluop_i    = EXE_DIV_OP;
    dividend_i = 32'd8;
    divisor_i  = 32'd2;
    wb_addr_i  = 5'd20;
    step();
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start_ready", 32'(ready_o), 32'd1);
    repeat (40) step();

    // Non-divide op is ignored.
    start_i    = 1'b1;
    aluop_i    = EXE_ADD_OP;
    dividend_i = 32'd8;
    divisor_i  = 32'd2;
    wb_addr_i  = 5'd21;
    step();
    start_i = 1'b0;
    check("add_ignored_ready", 32'(ready_o), 32'd1);
    repeat (40) step();

    // Second start during CALC: first result intact, single pulse.
    issue(EXE_DIV_OP, 32'd1000, 32'd7, 5'd4, 1'b1, 32'd142);
    repeat (5) step();
    start_i    = 1'b1;
    aluop_i    = EXE_MOD_OP;
    dividend_i = 32'd9;
    divisor_i  = 32'd2;
    wb_addr_i  = 5'd7;
    step();
    start_i = 1'b0;
    drain();
    repeat (40) step();

    // Reset mid-CALC returns everything to reset values.
    issue(EXE_DIVU_OP, 32'd50, 32'd5, 5'd3, 1'b0, 32'd0);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_wb_addr", 32'(wb_addr_o), 32'd0);
    rst = 1'b0;
    repeat (40) step();
    issue(EXE_MODU_OP, 32'd50, 32'd7, 5'd3, 1'b1, 32'd1);
    drain();
    repeat (5) step();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
